single_port_memory_responder: RTL

- Responder (slave) end of the single-port memory interface: a word-organised, byte-enabled synchronous RAM serving the CPU's load/store master.
- Read latency is configurable and pipelined, with one access per cycle.
- After reset it zero-fills the array and reports busy until done.
- Flags accesses outside DEPTH.
- Sits behind the data-memory master in the CPU top level.

---
 rtl/single_port_memory_responder_if.sv | 28 ++
 rtl/single_port_memory_responder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/single_port_memory_responder_if.sv
// Single-port memory bus between a load/store master and a RAM responder.
//   read_data    : responder -> master, read response word
//   write_data   : master -> responder, store data
//   address      : master -> responder, word index
//   write_enable : master -> responder, 1 = store, 0 = load
//   enable       : master -> responder, per-byte request strobes (any set = access)
//   byte_enable  : master -> responder, per-byte write mask
interface MemoryInterfaceSinglePort #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]   read_data;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [ADDR_WIDTH-1:0]   address;
  logic                    write_enable;
  logic [DATA_WIDTH/8-1:0] enable;
  logic [DATA_WIDTH/8-1:0] byte_enable;

  modport slave (
    output read_data,
    input  write_data, address, write_enable, enable, byte_enable
  );

  modport master (
    input  read_data,
    output write_data, address, write_enable, enable, byte_enable
  );
endinterface

// File: rtl/single_port_memory_responder.sv
// Word-organised, byte-enabled synchronous RAM answering a single-port
// load/store master. One access per cycle, reads return READ_LATENCY edges
// after the request edge. Optionally zero-fills the array after reset.
//   clk        : rising-edge clock
//   reset      : synchronous, active-high
//   mem        : slave side of the single-port memory bus
//   busy       : high while the array is being zero-filled; requests ignored
//   read_valid : one-cycle pulse with a read response on mem.read_data
//   addr_error : one-cycle pulse, response-aligned, for an out-of-range access

// One byte column of the array: write port plus combinational read; the
// read register lives in the parent's stage-1 pipeline register.
module spmr_byte_lane #(
  parameter int DEPTH = 1024,
  parameter int IW    = 10
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [7:0]    wr_byte,
  input  logic [IW-1:0] rd_idx,
  output logic [7:0]    rd_byte
);
  logic [7:0] ram [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_idx] <= wr_byte;
  end

  assign rd_byte = ram[rd_idx];
endmodule

module single_port_memory_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int DEPTH          = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  MemoryInterfaceSinglePort.slave mem,
  output logic                   busy,
  output logic                   read_valid,
  output logic                   addr_error
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int STAGES    = READ_LATENCY;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t  state, state_nxt;
  logic [IW-1:0] clr_cnt;

  // ---- clear / ready FSM ----
  always_ff @(posedge clk) begin
    if (reset) state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy = 1'b1;
        if (clr_cnt == IW'(DEPTH - 1)) state_nxt = ST_READY;
      end
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                 clr_cnt <= '0;
    else if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end

  // ---- request decode ----
  logic          in_range, access, wr_req, rd_req, clearing;
  logic [IW-1:0] idx, wr_idx;
  logic [NUM_LANES-1:0]      wr_en;
  logic [NUM_LANES-1:0][7:0] wr_bytes, lane_rd;

  // Compare in ADDR_WIDTH+1 bits so DEPTH == 2**ADDR_WIDTH still fits.
  assign in_range = ({1'b0, mem.address} < DEPTH_LIM);
  assign idx      = mem.address[IW-1:0];
  // Reset gating keeps a request coinciding with reset from touching the array.
  assign access   = (state == ST_READY) & (|mem.enable) & ~reset;
  assign wr_req   = access & mem.write_enable & in_range;
  assign rd_req   = access & ~mem.write_enable;
  assign clearing = (state == ST_CLEAR) & ~reset;
  assign wr_idx   = clearing ? clr_cnt : idx;
  assign wr_bytes = clearing ? '0 : mem.write_data;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wr_en[i] = clearing | (wr_req & mem.byte_enable[i]);

    spmr_byte_lane #(.DEPTH(DEPTH), .IW(IW)) u_lane (
      .clk     (clk),
      .wr_en   (wr_en[i]),
      .wr_idx  (wr_idx),
      .wr_byte (wr_bytes[i]),
      .rd_idx  (idx),
      .rd_byte (lane_rd[i])
    );
  end

  // ---- response pipeline ----
  // Stage 1 captures the array on the request edge; later stages shift.
  // Data registers advance only behind a valid read so the output word
  // holds between read responses.
  logic [STAGES:1]           vld_pipe, rd_pipe, err_pipe;
  logic [DATA_WIDTH-1:0]     dat_pipe [1:STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      rd_pipe  <= '0;
      err_pipe <= '0;
      for (int k = 1; k <= STAGES; k++) dat_pipe[k] <= '0;
    end else begin
      vld_pipe[1] <= access;
      rd_pipe[1]  <= ~mem.write_enable;
      err_pipe[1] <= ~in_range;
      // Out-of-range reads return zero rather than an aliased word.
      if (rd_req) dat_pipe[1] <= in_range ? lane_rd : '0;
      for (int k = 2; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        rd_pipe[k]  <= rd_pipe[k-1];
        err_pipe[k] <= err_pipe[k-1];
        if (vld_pipe[k-1] & rd_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  assign read_valid    = vld_pipe[STAGES] & rd_pipe[STAGES];
  assign addr_error    = vld_pipe[STAGES] & err_pipe[STAGES];
  assign mem.read_data = dat_pipe[STAGES];
endmodule
